// File: rtl/i2c_slave_ctrl_if.sv
// Bus bundle between the I2C slave transaction controller and its neighbours:
// edge/condition detectors, address comparator, FIFOs and the SDA selector.
interface i2c_slave_ctrl_if;
    logic       start_found;
    logic       stop_found;
    logic       scl_rise;
    logic       scl_fall;
    logic       sda_in;
    logic       address_match;
    logic       rw_bit;
    logic       rx_fifo_full;
    logic       tx_fifo_empty;
    logic [1:0] sda_mode;
    logic       rx_enable;
    logic       tx_enable;
    logic       load_data;
    logic       tx_fifo_pop;
    logic       rx_byte_done;
    logic       tx_underrun;
    logic       busy;

    modport slave (
        input  start_found, stop_found, scl_rise, scl_fall, sda_in,
        input  address_match, rw_bit, rx_fifo_full, tx_fifo_empty,
        output sda_mode, rx_enable, tx_enable, load_data,
        output tx_fifo_pop, rx_byte_done, tx_underrun, busy
    );

    modport master (
        output start_found, stop_found, scl_rise, scl_fall, sda_in,
        output address_match, rw_bit, rx_fifo_full, tx_fifo_empty,
        input  sda_mode, rx_enable, tx_enable, load_data,
        input  tx_fifo_pop, rx_byte_done, tx_underrun, busy
    );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction controller: tracks START/STOP and bit counts,
// drives the SDA selector code and RX/TX/FIFO strobes.
module i2c_slave_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input logic            clk,
    input logic            rst,
    i2c_slave_ctrl_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] CMAX = CW'(DATA_WIDTH);

    typedef enum logic [3:0] {
        IDLE, ADDR_RX, ADDR_CHK, ADDR_WAIT, ADDR_ACK,
        DATA_RX, DATA_CHK, DATA_WAIT, DATA_ACK,
        DATA_TX, MASTER_ACK, NACK, WAIT_STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          match_q, rw_q, ack_q, mack_q;
    logic [1:0]    mode_q;
    logic          rise, fall, ovr;
    logic          rx_en, tx_en, load;

    // A simultaneous rise/fall is treated as a rise only.
    assign rise    = bus.scl_rise;
    assign fall    = bus.scl_fall & ~bus.scl_rise;
    assign ovr     = bus.stop_found | bus.start_found;
    assign cnt_inc = (cnt == CMAX) ? cnt : cnt + CW'(1);

    always_comb begin
        rx_en            = 1'b0;
        tx_en            = 1'b0;
        load             = 1'b0;
        bus.rx_byte_done = 1'b0;
        if (!rst && !ovr) begin
            unique case (state)
                ADDR_RX, DATA_RX: rx_en = rise;
                ADDR_WAIT:  load = fall & match_q & rw_q;
                DATA_CHK:   bus.rx_byte_done = ~bus.rx_fifo_full;
                DATA_TX:    tx_en = fall & (cnt != CMAX);
                MASTER_ACK: load = fall & ~mack_q;
                default: ;
            endcase
        end
    end

    assign bus.rx_enable   = rx_en;
    assign bus.tx_enable   = tx_en;
    assign bus.load_data   = load;
    assign bus.tx_fifo_pop = load & ~bus.tx_fifo_empty;
    assign bus.tx_underrun = load & bus.tx_fifo_empty;
    assign bus.sda_mode    = mode_q;
    assign bus.busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            match_q <= 1'b0;
            rw_q    <= 1'b0;
            ack_q   <= 1'b0;
            mack_q  <= 1'b0;
            mode_q  <= 2'b00;
        end else if (bus.stop_found) begin
            state  <= IDLE;
            cnt    <= '0;
            mode_q <= 2'b00;
        end else if (bus.start_found) begin
            state  <= ADDR_RX;
            cnt    <= '0;
            mode_q <= 2'b00;
        end else begin
            unique case (state)
                ADDR_RX, DATA_RX: if (rise) begin
                    cnt <= cnt_inc;
                    if (cnt_inc == CMAX)
                        state <= (state == ADDR_RX) ? ADDR_CHK : DATA_CHK;
                end
                ADDR_CHK: begin
                    match_q <= bus.address_match;
                    rw_q    <= bus.rw_bit;
                    cnt     <= '0;
                    state   <= ADDR_WAIT;
                end
                ADDR_WAIT: if (fall) begin
                    state  <= match_q ? ADDR_ACK : NACK;
                    mode_q <= match_q ? 2'b01 : 2'b10;
                end
                ADDR_ACK: if (fall) begin
                    state  <= rw_q ? DATA_TX : DATA_RX;
                    mode_q <= rw_q ? 2'b11 : 2'b00;
                end
                DATA_CHK: begin
                    ack_q <= ~bus.rx_fifo_full;
                    cnt   <= '0;
                    state <= DATA_WAIT;
                end
                DATA_WAIT: if (fall) begin
                    state  <= ack_q ? DATA_ACK : NACK;
                    mode_q <= ack_q ? 2'b01 : 2'b10;
                end
                DATA_ACK: if (fall) begin
                    state  <= DATA_RX;
                    mode_q <= 2'b00;
                end
                DATA_TX: begin
                    if (rise) begin
                        cnt <= cnt_inc;
                    end else if (fall && cnt == CMAX) begin
                        state  <= MASTER_ACK;
                        mode_q <= 2'b00;
                        cnt    <= '0;
                    end
                end
                MASTER_ACK: begin
                    if (rise) begin
                        mack_q <= bus.sda_in;
                    end else if (fall) begin
                        state  <= mack_q ? WAIT_STOP : DATA_TX;
                        mode_q <= mack_q ? 2'b00 : 2'b11;
                    end
                end
                NACK: if (fall) begin
                    state  <= WAIT_STOP;
                    mode_q <= 2'b00;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Randomized transaction-level bench for i2c_slave_ctrl; expected SDA codes
// and strobe counts come from the I2C byte protocol, not from the RTL.
module tb_i2c_slave_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    i2c_slave_ctrl_if bus ();
    i2c_slave_ctrl #(.DATA_WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad = 0;
    int n_rx = 0, n_tx = 0, n_ld = 0, n_pop = 0;
    int n_done = 0, n_und = 0, n_und_ld = 0;

    always @(negedge clk) begin
        if (bus.rx_enable)    n_rx   <= n_rx + 1;
        if (bus.tx_enable)    n_tx   <= n_tx + 1;
        if (bus.load_data)    n_ld   <= n_ld + 1;
        if (bus.tx_fifo_pop)  n_pop  <= n_pop + 1;
        if (bus.rx_byte_done) n_done <= n_done + 1;
        if (bus.tx_underrun)  n_und  <= n_und + 1;
        if (bus.tx_underrun && bus.load_data) n_und_ld <= n_und_ld + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.start_found = 1'b1;
        tick();
        bus.start_found = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.stop_found = 1'b1;
        tick();
        bus.stop_found = 1'b0;
        tick();
    endtask

    // One SCL period: low gap, rise (mode sampled there), high gap, fall.
    task automatic bit_cycle(input logic b, output logic [1:0] m);
        repeat ($urandom_range(2, 4)) tick();
        bus.sda_in   = b;
        bus.rw_bit   = b;
        bus.scl_rise = 1'b1;
        @(negedge clk);
        m = bus.sda_mode;
        tick();
        bus.scl_rise = 1'b0;
        repeat ($urandom_range(2, 4)) tick();
        bus.scl_fall = 1'b1;
        tick();
        bus.scl_fall = 1'b0;
    endtask

    task automatic xfer_byte(input logic [8:0] bits, output logic [17:0] modes);
        logic [1:0] m;
        for (int i = 8; i >= 0; i--) begin
            bit_cycle(bits[i], m);
            modes[2*i +: 2] = m;
        end
    endtask

    function automatic logic [17:0] exp_m(input logic [1:0] body, input logic [1:0] last);
        return {body, body, body, body, body, body, body, body, last};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if (bus.sda_mode !== 2'b00) begin
            bad++; $display("FAIL reset_mode got=%b want=00", bus.sda_mode);
        end
        total++;
        if (bus.busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
        total++;
        if ({bus.rx_enable, bus.tx_enable, bus.load_data, bus.tx_fifo_pop,
             bus.rx_byte_done, bus.tx_underrun} !== 6'b0) begin
            bad++; $display("FAIL reset_strobes got=%b want=000000",
                {bus.rx_enable, bus.tx_enable, bus.load_data, bus.tx_fifo_pop,
                 bus.rx_byte_done, bus.tx_underrun});
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [7:0] d[3];
        logic [17:0] m;
        int nb, rx0, dn0, ld0;
        for (int it = 0; it < 3; it++) begin
            nb = (it == 0) ? 2 : int'($urandom_range(1, 3));
            d[0] = (it == 0) ? 8'hA5 : 8'($urandom);
            d[1] = (it == 0) ? 8'h3C : 8'($urandom);
            d[2] = 8'($urandom);
            rx0 = n_rx; dn0 = n_done; ld0 = n_ld;
            bus.address_match = 1'b1;
            pulse_start();
            xfer_byte({8'h84, 1'b1}, m);
            total++;
            if (m !== exp_m(2'b00, 2'b01)) begin
                bad++; $display("FAIL wr_addr_modes got=%h want=%h", m, exp_m(2'b00, 2'b01));
            end
            for (int k = 0; k < nb; k++) begin
                xfer_byte({d[k], 1'b1}, m);
                total++;
                if (m !== exp_m(2'b00, 2'b01)) begin
                    bad++; $display("FAIL wr_data%0d_modes got=%h want=%h", k, m, exp_m(2'b00, 2'b01));
                end
            end
            pulse_stop();
            total++;
            if (n_rx - rx0 !== 8 * (nb + 1)) begin
                bad++; $display("FAIL wr_rx_count got=%0d want=%0d", n_rx - rx0, 8 * (nb + 1));
            end
            total++;
            if (n_done - dn0 !== nb) begin
                bad++; $display("FAIL wr_done_count got=%0d want=%0d", n_done - dn0, nb);
            end
            total++;
            if (n_ld - ld0 !== 0) begin
                bad++; $display("FAIL wr_load_count got=%0d want=0", n_ld - ld0);
            end
            total++;
            if ({bus.busy, bus.sda_mode} !== 3'b000) begin
                bad++; $display("FAIL wr_idle got=%b want=000", {bus.busy, bus.sda_mode});
            end
        end
    endtask

    task automatic test_read();
        logic [17:0] m;
        int nb, rx0, tx0, ld0, pp0, un0;
        for (int it = 0; it < 3; it++) begin
            nb = (it == 0) ? 2 : int'($urandom_range(1, 3));
            rx0 = n_rx; tx0 = n_tx; ld0 = n_ld; pp0 = n_pop; un0 = n_und;
            bus.address_match = 1'b1;
            pulse_start();
            xfer_byte({8'h85, 1'b1}, m);
            total++;
            if (m !== exp_m(2'b00, 2'b01)) begin
                bad++; $display("FAIL rd_addr_modes got=%h want=%h", m, exp_m(2'b00, 2'b01));
            end
            for (int k = 0; k < nb; k++) begin
                xfer_byte({8'($urandom), (k == nb - 1)}, m);
                total++;
                if (m !== exp_m(2'b11, 2'b00)) begin
                    bad++; $display("FAIL rd_data%0d_modes got=%h want=%h", k, m, exp_m(2'b11, 2'b00));
                end
            end
            xfer_byte(9'($urandom), m);
            total++;
            if (m !== exp_m(2'b00, 2'b00)) begin
                bad++; $display("FAIL rd_waitstop_modes got=%h want=0", m);
            end
            total++;
            if (bus.busy !== 1'b1) begin
                bad++; $display("FAIL rd_waitstop_busy got=%b want=1", bus.busy);
            end
            total++;
            if ({n_ld - ld0, n_pop - pp0} !== {nb, nb}) begin
                bad++; $display("FAIL rd_load_pop got=%0d/%0d want=%0d", n_ld - ld0, n_pop - pp0, nb);
            end
            total++;
            if (n_tx - tx0 !== 7 * nb) begin
                bad++; $display("FAIL rd_tx_count got=%0d want=%0d", n_tx - tx0, 7 * nb);
            end
            total++;
            if ({n_rx - rx0, n_und - un0} !== {8, 0}) begin
                bad++; $display("FAIL rd_rx_und got=%0d/%0d want=8/0", n_rx - rx0, n_und - un0);
            end
            pulse_stop();
            total++;
            if (bus.busy !== 1'b0) begin
                bad++; $display("FAIL rd_stop_busy got=%b want=0", bus.busy);
            end
        end
    endtask

    task automatic test_nack_addr();
        logic [17:0] m;
        logic [6:0] a;
        int rx0, dn0, ld0;
        for (int it = 0; it < 2; it++) begin
            a = (it == 0) ? 7'h50 : 7'($urandom);
            if (a == 7'h42) a = 7'h43;
            rx0 = n_rx; dn0 = n_done; ld0 = n_ld;
            bus.address_match = 1'b0;
            pulse_start();
            xfer_byte({a, 1'($urandom), 1'b1}, m);
            total++;
            if (m !== exp_m(2'b00, 2'b10)) begin
                bad++; $display("FAIL nack_addr_modes got=%h want=%h", m, exp_m(2'b00, 2'b10));
            end
            xfer_byte(9'($urandom), m);
            total++;
            if (m !== exp_m(2'b00, 2'b00)) begin
                bad++; $display("FAIL nack_after_modes got=%h want=0", m);
            end
            total++;
            if ({n_rx - rx0, n_done - dn0, n_ld - ld0} !== {8, 0, 0}) begin
                bad++; $display("FAIL nack_strobes rx=%0d done=%0d ld=%0d want=8/0/0",
                    n_rx - rx0, n_done - dn0, n_ld - ld0);
            end
            total++;
            if (bus.busy !== 1'b1) begin
                bad++; $display("FAIL nack_busy got=%b want=1", bus.busy);
            end
            pulse_stop();
        end
        bus.address_match = 1'b1;
    endtask

    task automatic test_fifo_full();
        logic [17:0] m;
        int rx0, dn0;
        rx0 = n_rx; dn0 = n_done;
        bus.address_match = 1'b1;
        pulse_start();
        xfer_byte({8'h84, 1'b1}, m);
        bus.rx_fifo_full = 1'b1;
        xfer_byte({8'($urandom), 1'b1}, m);
        total++;
        if (m !== exp_m(2'b00, 2'b10)) begin
            bad++; $display("FAIL full_modes got=%h want=%h", m, exp_m(2'b00, 2'b10));
        end
        xfer_byte(9'($urandom), m);
        total++;
        if (m !== exp_m(2'b00, 2'b00)) begin
            bad++; $display("FAIL full_after_modes got=%h want=0", m);
        end
        total++;
        if ({n_rx - rx0, n_done - dn0} !== {16, 0}) begin
            bad++; $display("FAIL full_strobes rx=%0d done=%0d want=16/0", n_rx - rx0, n_done - dn0);
        end
        bus.rx_fifo_full = 1'b0;
        pulse_stop();
    endtask

    task automatic test_restart();
        logic [17:0] m;
        logic [1:0] b;
        int rx0, dn0;
        rx0 = n_rx; dn0 = n_done;
        bus.address_match = 1'b1;
        pulse_start();
        xfer_byte({8'h84, 1'b1}, m);
        for (int i = 0; i < 4; i++) bit_cycle(1'($urandom), b);
        pulse_start();
        xfer_byte({8'h84, 1'b1}, m);
        total++;
        if (m !== exp_m(2'b00, 2'b01)) begin
            bad++; $display("FAIL restart_addr_modes got=%h want=%h", m, exp_m(2'b00, 2'b01));
        end
        xfer_byte({8'($urandom), 1'b1}, m);
        total++;
        if (m !== exp_m(2'b00, 2'b01)) begin
            bad++; $display("FAIL restart_data_modes got=%h want=%h", m, exp_m(2'b00, 2'b01));
        end
        total++;
        if ({n_rx - rx0, n_done - dn0} !== {28, 1}) begin
            bad++; $display("FAIL restart_strobes rx=%0d done=%0d want=28/1", n_rx - rx0, n_done - dn0);
        end
        pulse_stop();
    endtask

    task automatic test_rst_mid_tx();
        logic [17:0] m;
        logic [1:0] b;
        bus.address_match = 1'b1;
        pulse_start();
        xfer_byte({8'h85, 1'b1}, m);
        for (int i = 0; i < 3; i++) bit_cycle(1'($urandom), b);
        repeat (2) tick();
        rst = 1'b1;
        bus.stop_found = 1'b1;
        bus.scl_fall = 1'b1;
        tick();
        rst = 1'b0;
        bus.stop_found = 1'b0;
        bus.scl_fall = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.sda_mode, bus.busy} !== 3'b000) begin
            bad++; $display("FAIL rst_tx_state got=%b want=000", {bus.sda_mode, bus.busy});
        end
        total++;
        if ({bus.rx_enable, bus.tx_enable, bus.load_data, bus.tx_fifo_pop,
             bus.rx_byte_done, bus.tx_underrun} !== 6'b0) begin
            bad++; $display("FAIL rst_tx_strobes got=%b want=000000",
                {bus.rx_enable, bus.tx_enable, bus.load_data, bus.tx_fifo_pop,
                 bus.rx_byte_done, bus.tx_underrun});
        end
        tick();
    endtask

    task automatic test_underrun();
        logic [17:0] m;
        int ld0, pp0, un0, ul0;
        ld0 = n_ld; pp0 = n_pop; un0 = n_und; ul0 = n_und_ld;
        bus.address_match = 1'b1;
        bus.tx_fifo_empty = 1'b1;
        pulse_start();
        xfer_byte({8'h85, 1'b1}, m);
        xfer_byte({8'($urandom), 1'b1}, m);
        total++;
        if (m !== exp_m(2'b11, 2'b00)) begin
            bad++; $display("FAIL und_modes got=%h want=%h", m, exp_m(2'b11, 2'b00));
        end
        total++;
        if ({n_ld - ld0, n_und - un0, n_und_ld - ul0} !== {1, 1, 1}) begin
            bad++; $display("FAIL und_pulses ld=%0d und=%0d both=%0d want=1/1/1",
                n_ld - ld0, n_und - un0, n_und_ld - ul0);
        end
        total++;
        if (n_pop - pp0 !== 0) begin
            bad++; $display("FAIL und_pop got=%0d want=0", n_pop - pp0);
        end
        bus.tx_fifo_empty = 1'b0;
        pulse_stop();
    endtask

    initial begin
        rst = 1'b1;
        bus.start_found = 1'b0;
        bus.stop_found = 1'b0;
        bus.scl_rise = 1'b0;
        bus.scl_fall = 1'b0;
        bus.sda_in = 1'b1;
        bus.address_match = 1'b0;
        bus.rw_bit = 1'b0;
        bus.rx_fifo_full = 1'b0;
        bus.tx_fifo_empty = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_nack_addr();
        test_fifo_full();
        test_restart();
        test_rst_mid_tx();
        test_underrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
